cocc_control_seq: RTL and testbench

//  Microcoded control sequencer for the 8-bit COCC CPU.
//  - Runs fetch/decode/execute over a 3-bit step counter.
//  - Drives bus-enable/load strobes for PC, MAR, RAM, IR, A, B and the ALU (mode, ee, eo).
//  - Consumes the ALU's registered flag_zero and flag_carry for conditional jumps.

---
 rtl/cocc_control_seq_pkg.sv | 41 ++++
 rtl/cocc_control_seq_rom.sv | 73 +++++++
 rtl/cocc_control_seq.sv | 78 +++++++
 tb/tb_cocc_control_seq.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/cocc_control_seq_pkg.sv
// cocc_control_seq_pkg: shared opcodes, ALU modes, step indices and control word for the COCC sequencer
package cocc_control_seq_pkg;
  localparam int STEP_W = 3;
  localparam logic [STEP_W-1:0] T0 = 3'd0;
  localparam logic [STEP_W-1:0] T1 = 3'd1;
  localparam logic [STEP_W-1:0] T2 = 3'd2;
  localparam logic [STEP_W-1:0] T3 = 3'd3;
  localparam logic [STEP_W-1:0] T4 = 3'd4;
  localparam logic [STEP_W-1:0] T5 = 3'd5;
  localparam logic [STEP_W-1:0] LAST_STEP = T5;
  typedef enum logic [3:0] {
    OP_NOP, OP_LDA, OP_ADD, OP_ADC, OP_SUB, OP_INC, OP_DEC, OP_AND,
    OP_OR, OP_XOR, OP_STA, OP_LDI, OP_JMP, OP_JZ, OP_JC, OP_HLT
  } opcode_t;
  typedef enum logic [2:0] {
    ALU_ADD, ALU_ADC, ALU_SUB, ALU_INC, ALU_DEC, ALU_AND, ALU_OR, ALU_XOR
  } alu_mode_t;
  typedef struct packed {
    logic      pc_out;
    logic      pc_inc;
    logic      pc_load;
    logic      mar_in;
    logic      ram_out;
    logic      ram_in;
    logic      ir_in;
    logic      ir_out;
    logic      a_in;
    logic      a_out;
    logic      b_in;
    alu_mode_t alu_mode;
    logic      alu_ee;
    logic      alu_eo;
    logic      halt;
  } ctrl_t;
  // ALU opcodes ADD..XOR are laid out so the mode is simply opcode - 2
  function automatic alu_mode_t alu_mode_of(input opcode_t op);
    logic [3:0] d;
    d = op - 4'd2;
    return alu_mode_t'(d[2:0]);
  endfunction
endpackage

// File: rtl/cocc_control_seq_rom.sv
// cocc_microcode_rom: combinational (opcode, step, flags) -> control word and last-step marker
module cocc_microcode_rom
  import cocc_control_seq_pkg::*;
(
  input  opcode_t           i_opcode,
  input  logic [STEP_W-1:0] i_step,
  input  logic              i_flag_zero,
  input  logic              i_flag_carry,
  output ctrl_t             o_ctrl,
  output logic              o_last
);
  alu_mode_t w_mode;
  assign w_mode = alu_mode_of(i_opcode);
  // fetch is shared by every opcode; from T2 the opcode selects its microprogram
  always_comb begin
    o_ctrl = '0;
    o_last = 1'b0;
    if (i_step == T0) begin
      o_ctrl.pc_out = 1'b1;
      o_ctrl.mar_in = 1'b1;
    end else if (i_step == T1) begin
      o_ctrl.ram_out = 1'b1;
      o_ctrl.ir_in   = 1'b1;
      o_ctrl.pc_inc  = 1'b1;
    end else begin
      case (i_opcode)
        OP_NOP: o_last = i_step == T2;
        OP_LDA, OP_STA: begin
          o_ctrl.ir_out  = i_step == T2;
          o_ctrl.mar_in  = i_step == T2;
          o_ctrl.ram_out = i_step == T3 && i_opcode == OP_LDA;
          o_ctrl.a_in    = i_step == T3 && i_opcode == OP_LDA;
          o_ctrl.a_out   = i_step == T3 && i_opcode == OP_STA;
          o_ctrl.ram_in  = i_step == T3 && i_opcode == OP_STA;
          o_last         = i_step == T3;
        end
        OP_ADD, OP_ADC, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
          o_ctrl.ir_out   = i_step == T2;
          o_ctrl.mar_in   = i_step == T2;
          o_ctrl.ram_out  = i_step == T3;
          o_ctrl.b_in     = i_step == T3;
          o_ctrl.alu_ee   = i_step == T4;
          o_ctrl.alu_eo   = i_step == T5;
          o_ctrl.a_in     = i_step == T5;
          o_ctrl.alu_mode = (i_step == T4 || i_step == T5) ? w_mode : ALU_ADD;
          o_last          = i_step == T5;
        end
        OP_INC, OP_DEC: begin
          o_ctrl.alu_ee   = i_step == T2;
          o_ctrl.alu_eo   = i_step == T3;
          o_ctrl.a_in     = i_step == T3;
          o_ctrl.alu_mode = (i_step == T2 || i_step == T3) ? w_mode : ALU_ADD;
          o_last          = i_step == T3;
        end
        OP_LDI: begin
          o_ctrl.ir_out = i_step == T2;
          o_ctrl.a_in   = i_step == T2;
          o_last        = i_step == T2;
        end
        OP_JMP, OP_JZ, OP_JC: begin
          o_ctrl.ir_out  = i_step == T2 && (i_opcode == OP_JMP || (i_opcode == OP_JZ ? i_flag_zero : i_flag_carry));
          o_ctrl.pc_load = o_ctrl.ir_out;
          o_last         = i_step == T2;
        end
        OP_HLT: begin
          o_ctrl.halt = i_step == T2;
          o_last      = i_step == T2;
        end
        default: o_last = 1'b0;
      endcase
    end
  end
endmodule

// File: rtl/cocc_control_seq.sv
// cocc_control_seq: step counter, RUN/HALT FSM and output gating around the microcode ROM
module cocc_control_seq
  import cocc_control_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_run,
  input  logic [3:0]        i_ir_opcode,
  input  logic              i_flag_zero,
  input  logic              i_flag_carry,
  output logic              o_pc_out,
  output logic              o_pc_inc,
  output logic              o_pc_load,
  output logic              o_mar_in,
  output logic              o_ram_out,
  output logic              o_ram_in,
  output logic              o_ir_in,
  output logic              o_ir_out,
  output logic              o_a_in,
  output logic              o_a_out,
  output logic              o_b_in,
  output logic [2:0]        o_alu_mode,
  output logic              o_alu_ee,
  output logic              o_alu_eo,
  output logic              o_halted,
  output logic              o_instr_done,
  output logic [STEP_W-1:0] o_step
);
  typedef enum logic {S_RUN, S_HALT} state_t;
  state_t            r_state, w_state_nx;
  logic [STEP_W-1:0] r_step, w_step_nx;
  ctrl_t             w_rom, w_ctrl;
  logic              w_last, w_act;
  cocc_microcode_rom u_rom (
    .i_opcode     (opcode_t'(i_ir_opcode)),
    .i_step       (r_step),
    .i_flag_zero  (i_flag_zero),
    .i_flag_carry (i_flag_carry),
    .o_ctrl       (w_rom),
    .o_last       (w_last)
  );
  assign w_act = rst_n && i_run && r_state == S_RUN;
  // state and step registers; reset aborts any instruction back to T0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RUN;
      r_step  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_step  <= w_step_nx;
    end
  end
  // HLT freezes the step where it is; otherwise advance and wrap at instruction end or LAST_STEP
  always_comb begin
    w_state_nx = r_state;
    w_step_nx  = r_step;
    if (w_act && w_rom.halt) w_state_nx = S_HALT;
    else if (w_act) w_step_nx = (w_last || r_step == LAST_STEP) ? '0 : r_step + 1'b1;
  end
  assign w_ctrl       = w_act ? w_rom : '0;
  assign o_pc_out     = w_ctrl.pc_out;
  assign o_pc_inc     = w_ctrl.pc_inc;
  assign o_pc_load    = w_ctrl.pc_load;
  assign o_mar_in     = w_ctrl.mar_in;
  assign o_ram_out    = w_ctrl.ram_out;
  assign o_ram_in     = w_ctrl.ram_in;
  assign o_ir_in      = w_ctrl.ir_in;
  assign o_ir_out     = w_ctrl.ir_out;
  assign o_a_in       = w_ctrl.a_in;
  assign o_a_out      = w_ctrl.a_out;
  assign o_b_in       = w_ctrl.b_in;
  assign o_alu_mode   = w_ctrl.alu_mode;
  assign o_alu_ee     = w_ctrl.alu_ee;
  assign o_alu_eo     = w_ctrl.alu_eo;
  assign o_halted     = rst_n && (r_state == S_HALT || w_ctrl.halt);
  assign o_instr_done = w_act && w_last;
  assign o_step       = rst_n ? r_step : '0;
endmodule

// File: tb/tb_cocc_control_seq.sv
// tb_cocc_control_seq: vector table, corner sequences and random run against an instruction-level model
module tb_cocc_control_seq;
  logic clk = 0, rst_n = 0, i_run = 0, i_flag_zero = 0, i_flag_carry = 0;
  logic [3:0] i_ir_opcode = 0;
  logic o_pc_out, o_pc_inc, o_pc_load, o_mar_in, o_ram_out, o_ram_in, o_ir_in, o_ir_out;
  logic o_a_in, o_a_out, o_b_in, o_alu_ee, o_alu_eo, o_halted, o_instr_done;
  logic [2:0] o_alu_mode, o_step;
  logic [20:0] dv;
  int n_checks = 0, n_fail = 0;
  int m_step = 0;
  bit m_halt = 0;
  int len_tab [16] = '{3, 4, 6, 6, 6, 4, 4, 6, 6, 6, 4, 3, 3, 3, 3, 3};
  int mode_tab [16] = '{0, 0, 0, 1, 2, 3, 4, 5, 6, 7, 0, 0, 0, 0, 0, 0};
  localparam logic [20:0] PO = 21'h100000, PI = 21'h80000, PL = 21'h40000, MI = 21'h20000;
  localparam logic [20:0] RO = 21'h10000, RI = 21'h8000, II = 21'h4000, IO = 21'h2000;
  localparam logic [20:0] AI = 21'h1000, AO = 21'h800, BI = 21'h400;
  localparam logic [20:0] EE = 21'h40, EO = 21'h20, HL = 21'h10, DN = 21'h8, ALL = 21'h1FFFFF;
  typedef struct {
    logic        run;
    logic [3:0]  op;
    logic        zf;
    logic        cf;
    logic [20:0] exp;
  } vec_t;
  vec_t vecs[$];
  cocc_control_seq dut (
    .clk(clk), .rst_n(rst_n), .i_run(i_run), .i_ir_opcode(i_ir_opcode),
    .i_flag_zero(i_flag_zero), .i_flag_carry(i_flag_carry),
    .o_pc_out(o_pc_out), .o_pc_inc(o_pc_inc), .o_pc_load(o_pc_load), .o_mar_in(o_mar_in),
    .o_ram_out(o_ram_out), .o_ram_in(o_ram_in), .o_ir_in(o_ir_in), .o_ir_out(o_ir_out),
    .o_a_in(o_a_in), .o_a_out(o_a_out), .o_b_in(o_b_in), .o_alu_mode(o_alu_mode),
    .o_alu_ee(o_alu_ee), .o_alu_eo(o_alu_eo), .o_halted(o_halted),
    .o_instr_done(o_instr_done), .o_step(o_step)
  );
  assign dv = {o_pc_out, o_pc_inc, o_pc_load, o_mar_in, o_ram_out, o_ram_in, o_ir_in, o_ir_out,
               o_a_in, o_a_out, o_b_in, o_alu_mode, o_alu_ee, o_alu_eo, o_halted, o_instr_done, o_step};
  // free-running clock
  always #5 clk = ~clk;
  // at most one bus driver in any cycle
  always @(negedge clk) begin
    if (rst_n) begin
      n_checks++;
      if ($countones({o_pc_out, o_ram_out, o_ir_out, o_a_out, o_alu_eo}) > 1) begin
        n_fail++;
        $display("FAIL bus_one_driver t=%0t drivers=%b required at most one",
                 $time, {o_pc_out, o_ram_out, o_ir_out, o_a_out, o_alu_eo});
      end
    end
  end
  function automatic logic [20:0] md(input int k);
    return 21'(k) << 7;
  endfunction
  // expected outputs from the instruction table, the current model step and the live flags
  function automatic logic [20:0] model(input logic run, input logic [3:0] op, input logic zf, input logic cf);
    logic [20:0] e;
    int s;
    s = m_step;
    e = 21'(s);
    if (m_halt) return e | HL;
    if (!run) return e;
    if (s == len_tab[op] - 1) e |= DN;
    if (s == 0) return e | PO | MI;
    if (s == 1) return e | RO | II | PI;
    case (op)
      4'h1: e |= (s == 2) ? IO | MI : RO | AI;
      4'h2, 4'h3, 4'h4, 4'h7, 4'h8, 4'h9:
        e |= (s == 2) ? IO | MI : (s == 3) ? RO | BI : (s == 4) ? EE | md(mode_tab[op]) : EO | AI | md(mode_tab[op]);
      4'h5, 4'h6: e |= (s == 2) ? EE | md(mode_tab[op]) : EO | AI | md(mode_tab[op]);
      4'hA: e |= (s == 2) ? IO | MI : AO | RI;
      4'hB: e |= IO | AI;
      4'hC: e |= IO | PL;
      4'hD: e |= zf ? IO | PL : 21'd0;
      4'hE: e |= cf ? IO | PL : 21'd0;
      4'hF: e |= HL;
      default: e |= 21'd0;
    endcase
    return e;
  endfunction
  task automatic advance(input logic run, input logic [3:0] op);
    if (m_halt || !run) return;
    if (op == 4'hF && m_step == 2) m_halt = 1;
    else m_step = (m_step == len_tab[op] - 1 || m_step == 5) ? 0 : m_step + 1;
  endtask
  task automatic chk(input string name, input logic [20:0] got, input logic [20:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%h required=%h", name, $time, got, exp);
    end
  endtask
  // one clock: drive, sample at negedge against the model (and an optional masked expectation), advance
  task automatic tick_x(input string name, input logic run, input logic [3:0] op, input logic zf,
                        input logic cf, input logic [20:0] mask, input logic [20:0] val);
    i_run = run; i_ir_opcode = op; i_flag_zero = zf; i_flag_carry = cf;
    @(negedge clk);
    chk({name, "_model"}, dv, model(run, op, zf, cf));
    if (mask != 0) chk(name, dv & mask, val);
    @(posedge clk);
    advance(run, op);
    #1;
  endtask
  task automatic tick(input logic run, input logic [3:0] op, input logic zf, input logic cf);
    tick_x("cyc", run, op, zf, cf, 21'd0, 21'd0);
  endtask
  task automatic do_reset();
    rst_n = 0;
    #1;
    chk("reset_outputs", dv, 21'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    m_step = 0;
    m_halt = 0;
  endtask
  task automatic add(input logic run, input logic [3:0] op, input logic zf, input logic cf, input logic [20:0] exp);
    vec_t v;
    v.run = run; v.op = op; v.zf = zf; v.cf = cf; v.exp = exp;
    vecs.push_back(v);
  endtask
  initial begin
    logic [3:0] op;
    add(1, 4'h1, 0, 0, PO | MI | 21'd0);
    add(1, 4'h1, 0, 0, RO | II | PI | 21'd1);
    add(1, 4'h1, 0, 0, IO | MI | 21'd2);
    add(1, 4'h1, 0, 0, RO | AI | DN | 21'd3);
    add(1, 4'h2, 0, 0, PO | MI | 21'd0);
    add(1, 4'h2, 0, 0, RO | II | PI | 21'd1);
    add(1, 4'h2, 0, 0, IO | MI | 21'd2);
    add(1, 4'h2, 0, 0, RO | BI | 21'd3);
    add(1, 4'h2, 0, 0, EE | md(0) | 21'd4);
    add(1, 4'h2, 0, 1, EO | AI | DN | md(0) | 21'd5);
    add(1, 4'hE, 0, 1, PO | MI | 21'd0);
    add(1, 4'hE, 0, 1, RO | II | PI | 21'd1);
    add(1, 4'hE, 0, 1, IO | PL | DN | 21'd2);
    add(1, 4'hD, 0, 0, PO | MI | 21'd0);
    add(1, 4'hD, 0, 0, RO | II | PI | 21'd1);
    add(1, 4'hD, 0, 1, DN | 21'd2);
    add(1, 4'hD, 1, 0, PO | MI | 21'd0);
    add(1, 4'hD, 1, 0, RO | II | PI | 21'd1);
    add(1, 4'hD, 1, 0, IO | PL | DN | 21'd2);
    add(1, 4'h5, 0, 0, PO | MI | 21'd0);
    add(1, 4'h5, 0, 0, RO | II | PI | 21'd1);
    add(1, 4'h5, 0, 0, EE | md(3) | 21'd2);
    add(1, 4'h5, 0, 0, EO | AI | DN | md(3) | 21'd3);
    add(1, 4'hA, 0, 0, PO | MI | 21'd0);
    add(1, 4'hA, 0, 0, RO | II | PI | 21'd1);
    add(1, 4'hA, 0, 0, IO | MI | 21'd2);
    add(1, 4'hA, 0, 0, AO | RI | DN | 21'd3);
    add(1, 4'hB, 0, 0, PO | MI | 21'd0);
    add(1, 4'hB, 0, 0, RO | II | PI | 21'd1);
    add(1, 4'hB, 0, 0, IO | AI | DN | 21'd2);
    add(1, 4'h0, 0, 0, PO | MI | 21'd0);
    add(1, 4'h0, 0, 0, RO | II | PI | 21'd1);
    add(1, 4'h0, 0, 0, DN | 21'd2);
    add(1, 4'h9, 0, 0, PO | MI | 21'd0);
    do_reset();
    foreach (vecs[i]) tick_x($sformatf("vec%0d", i), vecs[i].run, vecs[i].op, vecs[i].zf, vecs[i].cf, ALL, vecs[i].exp);
    do_reset();
    tick(1, 4'hF, 0, 0);
    tick(1, 4'hF, 0, 0);
    tick_x("hlt_T2", 1, 4'hF, 0, 0, ALL, HL | DN | 21'd2);
    for (int i = 0; i < 20; i++) tick_x("halted_idle", 1, 4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), ALL, HL | 21'd2);
    do_reset();
    tick_x("resume_T0", 1, 4'h0, 0, 0, ALL, PO | MI);
    tick(1, 4'h0, 0, 0);
    tick(1, 4'h0, 0, 0);
    tick(1, 4'h4, 0, 0);
    tick(1, 4'h4, 0, 0);
    tick(1, 4'h4, 0, 0);
    for (int i = 0; i < 3; i++) tick_x("stall_T3", 0, 4'h4, 1, 1, ALL, 21'd3);
    tick_x("resume_T3", 1, 4'h4, 0, 0, ALL, RO | BI | 21'd3);
    tick_x("sub_T4", 1, 4'h4, 0, 0, ALL, EE | md(2) | 21'd4);
    tick(1, 4'h4, 0, 0);
    for (int i = 0; i < 4; i++) tick(1, 4'h9, 0, 0);
    i_run = 1; i_ir_opcode = 4'h9;
    #1;
    chk("xor_T4", dv, EE | md(7) | 21'd4);
    rst_n = 0;
    #1;
    chk("async_reset", dv, 21'd0);
    @(posedge clk);
    #1;
    rst_n = 1;
    m_step = 0;
    m_halt = 0;
    tick_x("post_reset_T0", 1, 4'h9, 0, 0, ALL, PO | MI);
    op = 4'h0;
    for (int i = 0; i < 1500; i++) begin
      if ((m_halt && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0) do_reset();
      if (m_step == 0 && !m_halt) op = 4'($urandom_range(0, 15));
      tick($urandom_range(0, 5) != 0, op, 1'($urandom), 1'($urandom));
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
